timer_regs: RTL and testbench
=============================

Name: timer_regs

Overview:
- CPU-facing register front end for the millisecond timer. It is the stage directly upstream of the timer and feeds it.
- Holds the 16-bit duration as two 8-bit registers and issues a one-cycle start pulse. It tracks the timer's done flag to detect expiry.
- Provides a latched interrupt with enable, clear, overrun flag and optional auto-reload (periodic mode).
- Sits on the CPU's 8-bit peripheral bus. Its outputs drive the timer's time_ms and start inputs; the timer's done output returns into it.

Parameters:
- TIME_W, 16, width of the duration bus to the timer; fixed to two 8-bit registers, other values unsupported.

Ports:
- clk  in  1  system clock (27 MHz)
- rst  in  1  reset; asynchronous, active-high
- addr  in  2  register select: 0 TIME_LO, 1 TIME_HI, 2 CTRL, 3 STATUS
- wr_en  in  1  write strobe, sampled on posedge clk
- wr_data  in  8  write data
- rd_en  in  1  read strobe
- rd_data  out  8  read data, registered
- timer_done  in  1  done flag from timer (high when idle/expired)
- time_ms  out  16  {TIME_HI, TIME_LO} to timer
- start  out  1  one-cycle start pulse to timer
- irq  out  1  interrupt request, level

Behaviour:
- Reset (async, rst=1): TIME_LO=TIME_HI=0, IE=0, AUTO=0, pending=0, overrun=0, FSM=IDLE, start=0, rd_data=0, irq=0.
- Register write (wr_en=1):
  - addr0 loads TIME_LO; addr1 loads TIME_HI.
  - addr2 CTRL: bit0 START (write-1 pulse, not stored), bit1 IE (stored), bit2 AUTO (stored), bit3 IRQ_CLR (write-1 clears pending and overrun, not stored). Bits 7:4 ignored.
  - addr3 writes ignored.
- time_ms = {TIME_HI, TIME_LO} continuously. The timer samples it only on start, so writes during RUN affect the next launch only.
- Reads: when rd_en=1, rd_data updates at the next edge (1-cycle latency); otherwise it holds.
  - addr0/1 return TIME_LO/TIME_HI.
  - addr2 returns {5'b0, AUTO, IE, 1'b0}.
  - addr3 STATUS returns {4'b0, overrun, running, pending, timer_done}.
  - Reads have no side effects.
- FSM:
  - IDLE: a CTRL write with START=1 goes to LAUNCH.
  - LAUNCH: start=1 for exactly this cycle; next state RUN.
  - RUN: if timer_done=1, this is an expiry event. Go to LAUNCH if AUTO=1, else IDLE.
  - running=1 in LAUNCH and RUN.
  - START written while in LAUNCH or RUN is ignored (no restart, no second pulse).
- Expiry event: pending<=1. If pending was already 1 and IRQ_CLR is not written in the same cycle, overrun<=1.
- irq = pending & IE, combinational from registered state.
- Simultaneous IRQ_CLR and expiry: expiry wins, so pending=1 and overrun=0 after the edge.
- Duration 0: the timer's done stays high, so expiry occurs in the first RUN cycle (start to expiry = 2 cycles). With AUTO=1 this gives a LAUNCH/RUN period of 2 cycles.
- Clearing AUTO during RUN: the current expiry still sets pending, then the FSM returns to IDLE.
- Reset mid-run: the FSM returns to IDLE at once and start drops immediately. The timer is reset by the same rst.

Test Plan:
- Reset with rst asserted mid-RUN -> all outputs 0, STATUS read = 8'h01 (timer_done=1 from the reset timer).
- Write LO=8'hE8, HI=8'h03, CTRL=8'h03 -> time_ms=16'h03E8, start high exactly one cycle, running=1. After timer_done rises (bench-driven), pending=1, irq=1, FSM IDLE.
- Pending set, IE=0 -> irq=0. Write CTRL=8'h02 (IE=1) -> irq=1. Write CTRL=8'h0A -> pending=0, irq=0, IE still 1.
- AUTO=1, time_ms=0, START -> start pulses every 2nd cycle. Second expiry without clear sets overrun; STATUS reads 8'h0F.
- IRQ_CLR written in the same cycle as expiry with pending=1 -> pending=1, overrun=0.
- START written during RUN -> no extra start pulse. Writing TIME_LO during RUN changes time_ms but the FSM still waits for the original expiry.

Source files
------------

// File: rtl/timer_regs.sv
// CPU register front end for the millisecond timer: holds the duration,
// launches the timer, and latches expiry into a maskable interrupt.
module timer_regs #(
  parameter int TIME_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        addr,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  input  logic              timer_done,
  output logic [TIME_W-1:0] time_ms,
  output logic              start,
  output logic              irq
);

  // state   | meaning
  // IDLE    | timer not launched, waiting for a START write
  // LAUNCH  | start pulse to timer this cycle
  // RUN     | timer counting, waiting for done
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  time_lo_q, time_lo_d;
  logic [7:0]  time_hi_q, time_hi_d;
  logic        ie_q, ie_d;
  logic        auto_q, auto_d;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  rd_data_q, rd_data_d;

  logic        ctrl_wr;
  logic        start_wr;
  logic        clr_wr;
  logic        running;
  logic        expiry;

  assign ctrl_wr  = wr_en && (addr == 2'd2);
  assign start_wr = ctrl_wr && wr_data[0];
  assign clr_wr   = ctrl_wr && wr_data[3];
  assign running  = (state_q == LAUNCH) || (state_q == RUN);
  assign expiry   = (state_q == RUN) && timer_done;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_wr) state_d = LAUNCH;
      LAUNCH:  state_d = RUN;
      RUN:     if (timer_done) state_d = auto_q ? LAUNCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    time_lo_d = time_lo_q;
    time_hi_d = time_hi_q;
    ie_d      = ie_q;
    auto_d    = auto_q;
    if (wr_en) begin
      unique case (addr)
        2'd0: time_lo_d = wr_data;
        2'd1: time_hi_d = wr_data;
        2'd2: begin
          ie_d   = wr_data[1];
          auto_d = wr_data[2];
        end
        default: ;
      endcase
    end
  end

  // An expiry coinciding with IRQ_CLR still leaves pending set but drops overrun.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (clr_wr) begin
      pending_d = 1'b0;
      overrun_d = 1'b0;
    end
    if (expiry) begin
      pending_d = 1'b1;
      if (pending_q && !clr_wr) overrun_d = 1'b1;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      unique case (addr)
        2'd0:    rd_data_d = time_lo_q;
        2'd1:    rd_data_d = time_hi_q;
        2'd2:    rd_data_d = {5'b0, auto_q, ie_q, 1'b0};
        default: rd_data_d = {4'b0, overrun_q, running, pending_q, timer_done};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      time_lo_q <= 8'h00;
      time_hi_q <= 8'h00;
      ie_q      <= 1'b0;
      auto_q    <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      time_lo_q <= time_lo_d;
      time_hi_q <= time_hi_d;
      ie_q      <= ie_d;
      auto_q    <= auto_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign time_ms = {time_hi_q, time_lo_q};
  assign start   = (state_q == LAUNCH);
  assign irq     = pending_q && ie_q;
  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_timer_regs.sv
// Directed bench for timer_regs; the timer's done flag is driven by hand.
module tb_timer_regs;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        timer_done;
  logic [15:0] time_ms;
  logic        start;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] rv;

  timer_regs #(.TIME_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .timer_done (timer_done),
    .time_ms    (time_ms),
    .start      (start),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    rd_en = 1'b1;
    addr = a;
    tick();
    rd_en = 1'b0;
    d = rd_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    addr = 2'd0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    rd_en = 1'b0;
    timer_done = 1'b1;
    repeat (3) tick();
    chk("rst_start", {15'b0, start}, 16'h0000);
    chk("rst_irq", {15'b0, irq}, 16'h0000);
    chk("rst_time", time_ms, 16'h0000);
    chk("rst_rd", {8'h00, rd_data}, 16'h0000);
    rst = 1'b0;
    tick();

    // one-shot launch and expiry
    wr(2'd0, 8'hE8);
    wr(2'd1, 8'h03);
    chk("time_03e8", time_ms, 16'h03E8);
    wr(2'd2, 8'h03);
    chk("launch_start", {15'b0, start}, 16'h0001);
    timer_done = 1'b0;
    tick();
    chk("run_start_low", {15'b0, start}, 16'h0000);
    rd(2'd3, rv);
    chk("status_run", {8'h00, rv}, 16'h0004);
    chk("run_no_start", {15'b0, start}, 16'h0000);
    timer_done = 1'b1;
    tick();
    chk("expiry_irq", {15'b0, irq}, 16'h0001);
    rd(2'd3, rv);
    chk("status_expired", {8'h00, rv}, 16'h0003);
    rd(2'd0, rv);
    chk("rd_lo", {8'h00, rv}, 16'h00E8);
    rd(2'd1, rv);
    chk("rd_hi", {8'h00, rv}, 16'h0003);

    // interrupt enable and clear
    wr(2'd2, 8'h00);
    chk("irq_masked", {15'b0, irq}, 16'h0000);
    wr(2'd2, 8'h02);
    chk("irq_enabled", {15'b0, irq}, 16'h0001);
    wr(2'd2, 8'h0A);
    chk("irq_cleared", {15'b0, irq}, 16'h0000);
    rd(2'd2, rv);
    chk("ctrl_ie_kept", {8'h00, rv}, 16'h0002);
    wr(2'd3, 8'hFF);
    rd(2'd3, rv);
    chk("status_wr_ignored", {8'h00, rv}, 16'h0001);

    // periodic mode with zero duration
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h00);
    chk("time_zero", time_ms, 16'h0000);
    wr(2'd2, 8'h07);
    chk("auto_p1", {15'b0, start}, 16'h0001);
    tick();
    chk("auto_gap1", {15'b0, start}, 16'h0000);
    tick();
    chk("auto_p2", {15'b0, start}, 16'h0001);
    chk("auto_irq", {15'b0, irq}, 16'h0001);
    tick();
    chk("auto_gap2", {15'b0, start}, 16'h0000);
    tick();
    chk("auto_p3", {15'b0, start}, 16'h0001);
    rd(2'd3, rv);
    chk("status_overrun", {8'h00, rv}, 16'h000F);

    // clear coinciding with expiry
    wr(2'd2, 8'h0E);
    rd(2'd3, rv);
    chk("status_clr_vs_exp", {8'h00, rv}, 16'h0007);
    chk("clr_vs_exp_irq", {15'b0, irq}, 16'h0001);

    // START and TIME_LO writes during RUN
    timer_done = 1'b0;
    wr(2'd2, 8'h0A);
    wr(2'd2, 8'h03);
    chk("restart_ignored", {15'b0, start}, 16'h0000);
    tick();
    chk("restart_ignored2", {15'b0, start}, 16'h0000);
    wr(2'd0, 8'h55);
    chk("time_run_update", time_ms, 16'h0055);
    rd(2'd3, rv);
    chk("status_still_run", {8'h00, rv}, 16'h0004);
    timer_done = 1'b1;
    tick();
    rd(2'd3, rv);
    chk("status_auto_off", {8'h00, rv}, 16'h0003);

    // reset in the middle of a run
    wr(2'd2, 8'h0A);
    timer_done = 1'b0;
    wr(2'd2, 8'h03);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_start", {15'b0, start}, 16'h0000);
    chk("midrst_irq", {15'b0, irq}, 16'h0000);
    chk("midrst_time", time_ms, 16'h0000);
    chk("midrst_rd", {8'h00, rd_data}, 16'h0000);
    timer_done = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    rd(2'd3, rv);
    chk("midrst_status", {8'h00, rv}, 16'h0001);
    rd(2'd2, rv);
    chk("midrst_ctrl", {8'h00, rv}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
